// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and FSM encoding for the multi-cycle control unit.
package cpu_isa_pkg;

  localparam int unsigned CLS_W    = 2;
  localparam int unsigned SUB_W    = 2;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ALU_OP_W = 2;

  localparam logic [CLS_W-1:0] CLS_REG = 2'b00;
  localparam logic [CLS_W-1:0] CLS_IMM = 2'b01;
  localparam logic [CLS_W-1:0] CLS_BR  = 2'b10;
  localparam logic [CLS_W-1:0] CLS_MEM = 2'b11;

  localparam logic [SUB_W-1:0] SUB_JMP   = 2'b00;
  localparam logic [SUB_W-1:0] SUB_JZ    = 2'b01;
  localparam logic [SUB_W-1:0] SUB_LOAD  = 2'b00;
  localparam logic [SUB_W-1:0] SUB_STORE = 2'b01;

  localparam logic [3:0] OP_HALT    = 4'b1111;
  localparam logic [3:0] OP_ILLEGAL = 4'b1110;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [SUB_W-1:0] sub;
  } decode_t;

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts FETCH/MEM wait cycles; flags expiry on the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expire_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit ENABLED = (MEM_TIMEOUT > 0);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire_c = ENABLED && waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake, sticky HALT/FAULT, and a memory wait timeout.
module multicycle_control_unit
  import cpu_isa_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic                ifetch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                imm_mode,
  output logic                reg_write,
  output logic                halted,
  output logic                fault,
  output logic [STATE_W-1:0]  state
);

  state_t     state_q, state_d;
  decode_t    dec_q, dec_d;
  logic [3:0] op_lo;
  logic       op_hi_nz;
  logic       waiting;
  logic       expire_c;

  assign op_lo    = opcode[3:0];
  assign op_hi_nz = (opcode >> 4) != '0;
  assign waiting  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign state    = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_d != state_q),
    .waiting  (waiting),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  // Next state and per-state strobes; mem_ready/zero_flag feed through same cycle.
  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    ifetch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    alu_en    = 1'b0;
    alu_op    = '0;
    imm_mode  = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        ifetch   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          // Pulses are suppressed while reset is asserted.
          ir_load = rst_n;
          pc_inc  = rst_n;
          state_d = ST_DECODE;
        end else if (expire_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        dec_d.cls = op_lo[3:2];
        dec_d.sub = op_lo[1:0];
        if (op_hi_nz || (op_lo == OP_ILLEGAL)) state_d = ST_FAULT;
        else if (op_lo == OP_HALT)             state_d = ST_HALT;
        else                                   state_d = ST_EXEC;
      end
      ST_EXEC: begin
        unique case (dec_q.cls)
          CLS_REG, CLS_IMM: begin
            alu_en   = 1'b1;
            alu_op   = dec_q.sub;
            imm_mode = (dec_q.cls == CLS_IMM);
            state_d  = ST_WB;
          end
          CLS_BR: begin
            pc_load = (dec_q.sub == SUB_JMP) || zero_flag;
            state_d = ST_FETCH;
          end
          default: state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        mem_read  = (dec_q.sub == SUB_LOAD);
        mem_write = (dec_q.sub != SUB_LOAD);
        if (mem_ready)     state_d = (dec_q.sub == SUB_LOAD) ? ST_WB : ST_FETCH;
        else if (expire_c) state_d = ST_FAULT;
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder of the 8-bit RISC CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes per state.
- Handshakes with a shared instruction/data memory through mem_ready, and handles halt, illegal opcodes and memory timeout.
- Opcode width is parametrised for the wider-ISA variant.

Parameters:
- OPCODE_W, 4, opcode width (>=4); bits [OPCODE_W-1:4] must be zero for a legal instruction.
- MEM_TIMEOUT, 16, max wait cycles for mem_ready in FETCH/MEM; 0 disables the timeout.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode field from the instruction register; valid from DECODE onward.
- zero_flag  in  1  ALU zero flag; sampled in EXEC of JZ.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ifetch  out  1  current memory access is an instruction fetch.
- mem_read  out  1  memory read request, held until mem_ready.
- mem_write  out  1  memory write request, held until mem_ready.
- ir_load  out  1  load instruction register, one-cycle pulse.
- pc_inc  out  1  PC+1, one-cycle pulse.
- pc_load  out  1  load PC from branch target.
- alu_en  out  1  ALU result capture enable.
- alu_op  out  2  ALU operation.
- imm_mode  out  1  ALU B operand = immediate.
- reg_write  out  1  register file write enable.
- halted  out  1  HALT executed (sticky).
- fault  out  1  illegal opcode or memory timeout (sticky).
- state  out  3  current state, for debug.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, timeout count=0, halted=0, fault=0, decode register=0. All strobes are 0 except the FETCH-state outputs, mem_read=1 and ifetch=1, which assert in the first cycle after reset release.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Outputs are a function of the state register and the latched decode register, except where a mem_ready or zero_flag dependence is stated.
- Default value of every strobe in every state is 0.
- FETCH:
  - mem_read=1, ifetch=1.
  - When mem_ready=1: ir_load=1 and pc_inc=1 in that same cycle; next state DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle):
  - Latch class=opcode[3:2] and sub=opcode[1:0].
  - If opcode[OPCODE_W-1:4]!=0 or opcode==4'b1110: illegal, next state FAULT.
  - If opcode==4'b1111 (HALT): next state HALT.
  - Otherwise next state EXEC.
- EXEC (1 cycle):
  - class 00: alu_en=1, alu_op=sub; next WB.
  - class 01: same as class 00, plus imm_mode=1; next WB.
  - class 10: JMP (sub=00) pc_load=1; JZ (sub!=00) pc_load=zero_flag, combinational this cycle; next FETCH.
  - class 11: next MEM.
- MEM:
  - LOAD (sub=00): mem_read=1.
  - STORE (sub=01): mem_write=1.
  - Request is held until mem_ready=1. On mem_ready, LOAD goes to WB and STORE goes to FETCH.
- WB (1 cycle): reg_write=1; next FETCH.
- HALT: halted=1; absorbing until reset; all strobes 0.
- FAULT: fault=1; absorbing until reset; all strobes 0.
- Timeout counter:
  - Cleared on every state change.
  - Increments on each FETCH/MEM cycle with mem_ready=0.
  - If MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT-1 with mem_ready still 0, next state FAULT. The access is abandoned and the request drops in the FAULT cycle.
  - mem_ready arriving on that same cycle wins and completes normally.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-instruction aborts immediately; no strobe pulses after rst_n falls.
- Cycle counts with mem_ready=1 on the first request cycle:
  - ALU op: 4 cycles.
  - Branch: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode class constants: CLS_REG=2'b00, CLS_IMM=2'b01, CLS_BR=2'b10, CLS_MEM=2'b11;
  - sub-op constants: JMP, JZ, LOAD, STORE;
  - OP_HALT=4'b1111 and OP_ILLEGAL=4'b1110;
  - state encoding constants.
- One natural sub-module: mem_wait_timer (counter, clear, expiry flag), parametrised by MEM_TIMEOUT and CNT_W.

Test Plan:
- Reset, then ADD (opcode 0000) with mem_ready tied high. Required: state sequence 0,1,2,4,0; alu_en and alu_op=00 in cycle 3; reg_write=1 only in cycle 4.
- ADDI (0101), then LOAD (1100) with mem_ready low for 3 MEM cycles. Required: imm_mode=1 and alu_op=01 in EXEC; mem_read held for 4 MEM cycles; reg_write one cycle after mem_ready; ifetch=0 throughout MEM.
- JZ (1001) with zero_flag=0, then with zero_flag=1. Required: pc_load=0, then pc_load=1 in EXEC; both return to FETCH with no reg_write.
- STORE (1101) with mem_ready tied low and MEM_TIMEOUT=4. Required: mem_write held for 4 cycles, then FAULT; fault=1 sticky; mem_write=0 from then on. Repeat with mem_ready on the 4th cycle: completes normally to FETCH.
- HALT (1111), and separately 1110 and (OPCODE_W=6) 010000. Required: halted=1 (first case) or fault=1 (other cases) from the cycle after DECODE, stable for 20 cycles; no strobes.
- rst_n pulsed low mid-MEM of LOAD. Required: outputs and state return to reset values asynchronously; after release, FETCH with mem_read=1 and ifetch=1; no reg_write for the aborted LOAD.
